// File: rtl/rv_pkg.sv
// Shared definitions for the load/store unit APB master.
//   lsu_state_t        : bus FSM state encoding
//   STORE_* / LOAD_*   : storeType / loadType instruction encodings
package rv_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } lsu_state_t;

    localparam logic [1:0] STORE_SB = 2'b00;
    localparam logic [1:0] STORE_SH = 2'b01;
    localparam logic [1:0] STORE_SW = 2'b10;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the LSU.
//   is_store, store_type, load_type, addr_lo : access description
//   wdata      : raw store data (rs2)
//   prdata     : raw bus read word
//   strb       : byte strobes (0000 for loads)
//   wdata_lane : store data replicated across the addressed lanes
//   load_data  : extracted and sign/zero-extended load value
//   misaligned : misaligned address or illegal type encoding
module lsu_align
    import rv_pkg::*;
(
    input  logic        is_store,
    input  logic [1:0]  store_type,
    input  logic [2:0]  load_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] prdata,
    output logic [3:0]  strb,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_byte    = prdata[{addr_lo, 3'b000} +: 8];
        rd_half    = prdata[{addr_lo[1], 4'b0000} +: 16];
        strb       = '0;
        wdata_lane = wdata;
        load_data  = '0;
        misaligned = 1'b0;
        if (is_store) begin
            case (store_type)
                STORE_SB: begin
                    strb       = 4'b0001 << addr_lo;
                    wdata_lane = {4{wdata[7:0]}};
                end
                STORE_SH: begin
                    strb       = 4'b0011 << addr_lo;
                    wdata_lane = {2{wdata[15:0]}};
                    misaligned = addr_lo[0];
                end
                STORE_SW: begin
                    strb       = 4'b1111;
                    misaligned = |addr_lo;
                end
                default: misaligned = 1'b1;
            endcase
        end else begin
            case (load_type)
                LOAD_LB:  load_data = {{24{rd_byte[7]}}, rd_byte};
                LOAD_LBU: load_data = {24'h0, rd_byte};
                LOAD_LH: begin
                    load_data  = {{16{rd_half[15]}}, rd_half};
                    misaligned = addr_lo[0];
                end
                LOAD_LHU: begin
                    load_data  = {16'h0, rd_half};
                    misaligned = addr_lo[0];
                end
                LOAD_LW: begin
                    load_data  = prdata;
                    misaligned = |addr_lo;
                end
                default: misaligned = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/lsu_apb_master.sv
// Load/store unit APB master: turns one core data-memory request into one
// APB transfer (IDLE -> SETUP -> ACCESS -> DONE), stalling the core meanwhile.
//   clk, reset (async, active low)
//   req, dataMem_wr_en, storeType, loadType, addr, wdata : core request
//   rdata, stall, done, err                               : core response
//   PADDR, PWRITE, PSEL, PENABLE, PWDATA, PSTRB           : APB request
//   PRDATA, PREADY, PSLVERR                               : APB response
// Optional: define LSU_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYCLES consecutive PREADY=0 cycles.
module lsu_apb_master
    import rv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        dataMem_wr_en,
    input  logic [1:0]  storeType,
    input  logic [2:0]  loadType,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic        PSEL,
    output logic        PENABLE,
    output logic [31:0] PWDATA,
    output logic [3:0]  PSTRB,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    lsu_state_t  state;
    logic        lat_store;
    logic [1:0]  lat_st_type;
    logic [2:0]  lat_ld_type;
    logic [1:0]  lat_addr_lo;

    logic        sel_store;
    logic [1:0]  sel_st_type;
    logic [2:0]  sel_ld_type;
    logic [1:0]  sel_addr_lo;
    logic [3:0]  al_strb;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_misaligned;

    // One aligner serves both ends: in IDLE it sees the incoming request
    // (strobes, lanes, legality); afterwards the latched type/offset so the
    // returning PRDATA is extracted with the accepted instruction's format.
    always_comb begin
        sel_store   = lat_store;
        sel_st_type = lat_st_type;
        sel_ld_type = lat_ld_type;
        sel_addr_lo = lat_addr_lo;
        if (state == S_IDLE) begin
            sel_store   = dataMem_wr_en;
            sel_st_type = storeType;
            sel_ld_type = loadType;
            sel_addr_lo = addr[1:0];
        end
    end

    lsu_align u_align (
        .is_store   (sel_store),
        .store_type (sel_st_type),
        .load_type  (sel_ld_type),
        .addr_lo    (sel_addr_lo),
        .wdata      (wdata),
        .prdata     (PRDATA),
        .strb       (al_strb),
        .wdata_lane (al_wdata),
        .load_data  (al_load),
        .misaligned (al_misaligned)
    );

    // Gated by reset so the core is released the instant reset asserts.
    assign stall = reset && ((state == S_IDLE && req) ||
                             state == S_SETUP || state == S_ACCESS);

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            lat_store   <= 1'b0;
            lat_st_type <= '0;
            lat_ld_type <= '0;
            lat_addr_lo <= '0;
            rdata       <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWDATA      <= '0;
            PSTRB       <= '0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (req) begin
                        lat_store   <= dataMem_wr_en;
                        lat_st_type <= storeType;
                        lat_ld_type <= loadType;
                        lat_addr_lo <= addr[1:0];
                        if (al_misaligned) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                            rdata <= '0;
                        end else begin
                            state  <= S_SETUP;
                            PSEL   <= 1'b1;
                            PADDR  <= {addr[31:2], 2'b00};
                            PWRITE <= dataMem_wr_en;
                            PWDATA <= al_wdata;
                            PSTRB  <= dataMem_wr_en ? al_strb : 4'b0000;
                        end
                    end
                end
                S_SETUP: begin
                    state   <= S_ACCESS;
                    PENABLE <= 1'b1;
`ifdef LSU_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        state   <= S_DONE;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        done    <= 1'b1;
                        if (PSLVERR) begin
                            err   <= 1'b1;
                            rdata <= '0;
                        end else begin
                            err <= 1'b0;
                            if (!lat_store) begin
                                rdata <= al_load;
                            end
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state   <= S_DONE;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        rdata   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_apb_master.sv
module tb_lsu_apb_master;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        dataMem_wr_en;
    logic [1:0]  storeType;
    logic [2:0]  loadType;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    lsu_apb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .dataMem_wr_en(dataMem_wr_en),
        .storeType(storeType), .loadType(loadType), .addr(addr), .wdata(wdata),
        .rdata(rdata), .stall(stall), .done(done), .err(err),
        .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    // Captured by run_txn
    logic        cap_psel, cap_setup_ok, cap_stable, cap_stall_ok, cap_done;
    logic        cap_psel_at_done, cap_err, cap_pwrite;
    logic [31:0] cap_paddr, cap_pwdata, cap_rdata;
    logic [3:0]  cap_pstrb;
    int          cap_cycles;

    // Issues one request, acts as an APB slave that raises PREADY after
    // 'waits' wait-state cycles, and returns once the unit is IDLE again.
    task automatic run_txn(input logic wr, input logic [1:0] st, input logic [2:0] lt,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] prd, input logic slv, input int waits);
        int acc;
        @(negedge clk);
        req = 1'b1; dataMem_wr_en = wr; storeType = st; loadType = lt;
        addr = a; wdata = wd; PRDATA = prd; PREADY = 1'b0; PSLVERR = 1'b0;
        #1;
        cap_stall_ok = (stall === 1'b1);
        cap_psel = 1'b0; cap_setup_ok = 1'b1; cap_stable = 1'b1; cap_done = 1'b0;
        cap_psel_at_done = 1'b0; cap_err = 1'b0; cap_rdata = '0; cap_cycles = 0;
        cap_paddr = '0; cap_pwdata = '0; cap_pstrb = '0; cap_pwrite = 1'b0;
        acc = 0;
        for (int c = 0; c < 300 && !cap_done; c++) begin
            @(posedge clk); #1;
            cap_cycles++;
            req = 1'b0;
            if (done === 1'b1) begin
                cap_done = 1'b1;
                cap_err = err; cap_rdata = rdata; cap_psel_at_done = PSEL;
                if (stall !== 1'b0) cap_stall_ok = 1'b0;
                PREADY = 1'b0; PSLVERR = 1'b0;
            end else begin
                if (stall !== 1'b1) cap_stall_ok = 1'b0;
                if (PSEL === 1'b1) begin
                    if (!cap_psel) begin
                        cap_psel = 1'b1;
                        cap_paddr = PADDR; cap_pwdata = PWDATA;
                        cap_pstrb = PSTRB; cap_pwrite = PWRITE;
                        if (PENABLE !== 1'b0) cap_setup_ok = 1'b0;
                    end else if (PADDR !== cap_paddr || PWDATA !== cap_pwdata ||
                                 PSTRB !== cap_pstrb || PWRITE !== cap_pwrite) begin
                        cap_stable = 1'b0;
                    end
                    if (PENABLE === 1'b1) begin
                        acc++;
                        PREADY  = (acc > waits);
                        PSLVERR = slv && (acc > waits);
                    end else begin
                        PREADY = 1'b0;
                    end
                end
            end
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  st;
        logic [2:0]  lt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic        slv;
        int          waits;
        logic        exp_psel;
        logic [3:0]  exp_pstrb;
        logic [31:0] exp_pwdata;
        logic        chk_pwdata;
        logic        exp_err;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[18];

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int exp_cyc;

        //            wr    st     lt      addr          wdata         prdata        slv w  psel strb   pwdata        chkw err  chkr rdata
        vecs[0]  = '{1'b1, 2'b10, 3'b000, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0,        1'b0, 0, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[1]  = '{1'b1, 2'b00, 3'b000, 32'h1000_0003, 32'h1234_5678, 32'h0,        1'b0, 1, 1'b1, 4'h8, 32'h7878_7878, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[2]  = '{1'b1, 2'b01, 3'b000, 32'h1000_0002, 32'h0000_ABCD, 32'h0,        1'b0, 0, 1'b1, 4'hC, 32'hABCD_ABCD, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 2'b00, 3'b000, 32'h1000_0000, 32'h0000_00A5, 32'h0,        1'b0, 0, 1'b1, 4'h1, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[4]  = '{1'b0, 2'b00, 3'b000, 32'h1000_0001, 32'h0,         32'h0000_8000, 1'b0, 0, 1'b1, 4'h0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hFFFF_FF80};
        vecs[5]  = '{1'b0, 2'b00, 3'b100, 32'h1000_0001, 32'h0,         32'h0000_8000, 1'b0, 2, 1'b1, 4'h0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_0080};
        vecs[6]  = '{1'b0, 2'b00, 3'b001, 32'h1000_0002, 32'h0,         32'h8001_0000, 1'b0, 0, 1'b1, 4'h0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hFFFF_8001};
        vecs[7]  = '{1'b0, 2'b00, 3'b101, 32'h1000_0002, 32'h0,         32'h8001_0000, 1'b0, 0, 1'b1, 4'h0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_8001};
        vecs[8]  = '{1'b0, 2'b00, 3'b010, 32'h1000_0008, 32'h0,         32'hCAFE_F00D, 1'b0, 3, 1'b1, 4'h0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hCAFE_F00D};
        vecs[9]  = '{1'b1, 2'b10, 3'b000, 32'h1000_000C, 32'h1122_3344, 32'h0,        1'b0, 0, 1'b1, 4'hF, 32'h1122_3344, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D};
        vecs[10] = '{1'b0, 2'b00, 3'b010, 32'h1000_0002, 32'h0,         32'h5555_5555, 1'b0, 0, 1'b0, 4'h0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 2'b00, 3'b000, 32'h1000_0002, 32'h0,         32'h00FF_0000, 1'b0, 0, 1'b1, 4'h0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF};
        vecs[12] = '{1'b0, 2'b00, 3'b011, 32'h1000_0000, 32'h0,         32'h5555_5555, 1'b0, 0, 1'b0, 4'h0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0};
        vecs[13] = '{1'b0, 2'b00, 3'b001, 32'h1000_0000, 32'h0,         32'h0000_7FFF, 1'b0, 0, 1'b1, 4'h0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_7FFF};
        vecs[14] = '{1'b0, 2'b00, 3'b010, 32'h1000_0010, 32'h0,         32'h1234_5678, 1'b1, 1, 1'b1, 4'h0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0};
        vecs[15] = '{1'b1, 2'b01, 3'b000, 32'h1000_0001, 32'h0000_1111, 32'h0,        1'b0, 0, 1'b0, 4'h0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0};
        vecs[16] = '{1'b1, 2'b11, 3'b000, 32'h1000_0000, 32'h0000_2222, 32'h0,        1'b0, 0, 1'b0, 4'h0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0};
        vecs[17] = '{1'b0, 2'b00, 3'b100, 32'h1000_0003, 32'h0,         32'h9A00_0000, 1'b0, 0, 1'b1, 4'h0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_009A};

        // Reset state, with req held high to show stall is forced low.
        reset = 1'b0; req = 1'b1; dataMem_wr_en = 1'b0; storeType = '0; loadType = '0;
        addr = 32'h1000_0000; wdata = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        #23;
        check("rst_ctrl", {25'h0, PSEL, PENABLE, PWRITE, stall, done, err, |PSTRB}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_paddr", PADDR, 32'h0);
        check("rst_pwdata", PWDATA, 32'h0);
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            run_txn(vecs[i].wr, vecs[i].st, vecs[i].lt, vecs[i].addr, vecs[i].wdata,
                    vecs[i].prdata, vecs[i].slv, vecs[i].waits);
            a = vecs[i].addr;
            exp_cyc = vecs[i].exp_psel ? 3 + vecs[i].waits : 1;
            check($sformatf("v%0d_done", i), {31'h0, cap_done}, 32'h1);
            check($sformatf("v%0d_psel", i), {31'h0, cap_psel}, {31'h0, vecs[i].exp_psel});
            check($sformatf("v%0d_cycles", i), cap_cycles, exp_cyc);
            check($sformatf("v%0d_err", i), {31'h0, cap_err}, {31'h0, vecs[i].exp_err});
            check($sformatf("v%0d_stall", i), {31'h0, cap_stall_ok}, 32'h1);
            check($sformatf("v%0d_psel_done", i), {31'h0, cap_psel_at_done}, 32'h0);
            if (vecs[i].exp_psel) begin
                check($sformatf("v%0d_paddr", i), cap_paddr, {a[31:2], 2'b00});
                check($sformatf("v%0d_pstrb", i), {28'h0, cap_pstrb}, {28'h0, vecs[i].exp_pstrb});
                check($sformatf("v%0d_pwrite", i), {31'h0, cap_pwrite}, {31'h0, vecs[i].wr});
                check($sformatf("v%0d_setup", i), {31'h0, cap_setup_ok}, 32'h1);
                check($sformatf("v%0d_stable", i), {31'h0, cap_stable}, 32'h1);
                if (vecs[i].chk_pwdata)
                    check($sformatf("v%0d_pwdata", i), cap_pwdata, vecs[i].exp_pwdata);
            end
            if (vecs[i].chk_rdata)
                check($sformatf("v%0d_rdata", i), cap_rdata, vecs[i].exp_rdata);
        end

        // rdata/err hold after completion while idle.
        repeat (3) @(posedge clk);
        #1;
        check("hold_rdata", rdata, 32'h0000_009A);
        check("hold_err_done", {30'h0, err, done}, 32'h0);

        // Long PREADY=0 wait: aborts with the timeout, otherwise completes.
`ifdef LSU_TIMEOUT_EN
        run_txn(1'b0, 2'b00, 3'b010, 32'h1000_0020, 32'h0, 32'h0000_0055, 1'b0, 1000);
        check("to_done", {31'h0, cap_done}, 32'h1);
        check("to_cycles", cap_cycles, 2 + TO);
        check("to_err", {31'h0, cap_err}, 32'h1);
        check("to_rdata", cap_rdata, 32'h0);
        check("to_psel", {31'h0, cap_psel_at_done}, 32'h0);
`else
        run_txn(1'b0, 2'b00, 3'b010, 32'h1000_0020, 32'h0, 32'h0000_0055, 1'b0, 100);
        check("long_done", {31'h0, cap_done}, 32'h1);
        check("long_cycles", cap_cycles, 103);
        check("long_err", {31'h0, cap_err}, 32'h0);
        check("long_rdata", cap_rdata, 32'h0000_0055);
        check("long_stable", {31'h0, cap_stable}, 32'h1);
`endif

        // Reset asserted in the middle of ACCESS.
        @(negedge clk);
        req = 1'b1; dataMem_wr_en = 1'b0; loadType = 3'b010; addr = 32'h1000_0024;
        PREADY = 1'b0; PSLVERR = 1'b0;
        for (int c = 0; c < 10 && PENABLE !== 1'b1; c++) begin
            @(posedge clk); #1;
            req = 1'b0;
        end
        check("mid_in_access", {30'h0, PSEL, PENABLE}, 32'h3);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_outs", {28'h0, PSEL, PENABLE, stall, done}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        run_txn(1'b0, 2'b00, 3'b010, 32'h1000_0028, 32'h0, 32'h0BAD_F00D, 1'b0, 0);
        check("post_rst_done", {31'h0, cap_done}, 32'h1);
        check("post_rst_cycles", cap_cycles, 3);
        check("post_rst_rdata", cap_rdata, 32'h0BAD_F00D);
        check("post_rst_err", {31'h0, cap_err}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
